// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory request/data/response port between the I- and
//            D-cache; read-owner FIFO steers response beats back to the issuer.
// Config   : MEM_ARB_RR_EN defined -> round-robin ties, else dc wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_BITS   = 28,
  parameter int DATA_BITS   = 128,
  parameter int DATA_CYCLES = 4,
  parameter int MAX_OUTST   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,

  input  logic                   ic_req_val_i,
  output logic                   ic_req_rdy_o,
  input  logic [ADDR_BITS-1:0]   ic_req_addr_i,
  input  logic                   ic_req_rw_i,
  input  logic                   ic_req_data_valid_i,
  output logic                   ic_req_data_ready_o,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits_i,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask_i,
  output logic                   ic_resp_val_o,
  output logic [DATA_BITS-1:0]   ic_resp_data_o,

  input  logic                   dc_req_val_i,
  output logic                   dc_req_rdy_o,
  input  logic [ADDR_BITS-1:0]   dc_req_addr_i,
  input  logic                   dc_req_rw_i,
  input  logic                   dc_req_data_valid_i,
  output logic                   dc_req_data_ready_o,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits_i,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask_i,
  output logic                   dc_resp_val_o,
  output logic [DATA_BITS-1:0]   dc_resp_data_o,

  output logic                   mem_req_val_o,
  input  logic                   mem_req_rdy_i,
  output logic [ADDR_BITS-1:0]   mem_req_addr_o,
  output logic                   mem_req_rw_o,
  output logic                   mem_req_data_valid_o,
  input  logic                   mem_req_data_ready_i,
  output logic [DATA_BITS-1:0]   mem_req_data_bits_o,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask_o,
  input  logic                   mem_resp_val_i,
  input  logic [DATA_BITS-1:0]   mem_resp_data_i
);

  localparam int PTR_W  = $clog2(MAX_OUTST);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUTST);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 wowner_q, wowner_d;
  logic [BEAT_W-1:0]    wbeat_q, wbeat_d;
  logic [BEAT_W-1:0]    rbeat_q;
  logic [MAX_OUTST-1:0] owner_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic fifo_empty, fifo_full, resp_fire, pop, push, rd_block;
  logic ic_elig, dc_elig, grant_dc, in_idle, in_wdata, hdr_fire, data_fire;

  // Owner encoding in the FIFO and in wowner: 0 = ic, 1 = dc.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign resp_fire  = mem_resp_val_i & ~fifo_empty;
  assign pop        = resp_fire & (rbeat_q == LAST_BEAT);

  // A full FIFO still takes a read if a slot frees on this very edge.
  assign rd_block = fifo_full & ~pop;
  assign ic_elig  = ic_req_val_i & (ic_req_rw_i | ~rd_block);
  assign dc_elig  = dc_req_val_i & (dc_req_rw_i | ~rd_block);

  assign in_idle  = (state_q == IDLE);
  assign in_wdata = (state_q == WDATA);

`ifdef MEM_ARB_RR_EN
  logic rr_q;  // client preferred on the next tie (0 = ic)

  assign grant_dc = dc_elig & (~ic_elig | rr_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q <= 1'b0;
    end else if (hdr_fire) begin
      rr_q <= ~grant_dc;
    end
  end
`else
  assign grant_dc = dc_elig;
`endif

  assign mem_req_val_o  = in_idle & (ic_elig | dc_elig);
  assign mem_req_addr_o = grant_dc ? dc_req_addr_i : ic_req_addr_i;
  assign mem_req_rw_o   = grant_dc ? dc_req_rw_i : ic_req_rw_i;
  assign ic_req_rdy_o   = in_idle & ic_elig & ~grant_dc & mem_req_rdy_i;
  assign dc_req_rdy_o   = in_idle & grant_dc & mem_req_rdy_i;
  assign hdr_fire       = mem_req_val_o & mem_req_rdy_i;
  assign push           = hdr_fire & ~mem_req_rw_o;

  assign mem_req_data_valid_o = in_wdata & (wowner_q ? dc_req_data_valid_i : ic_req_data_valid_i);
  assign mem_req_data_bits_o  = wowner_q ? dc_req_data_bits_i : ic_req_data_bits_i;
  assign mem_req_data_mask_o  = wowner_q ? dc_req_data_mask_i : ic_req_data_mask_i;
  assign ic_req_data_ready_o  = in_wdata & ~wowner_q & mem_req_data_ready_i;
  assign dc_req_data_ready_o  = in_wdata & wowner_q & mem_req_data_ready_i;
  assign data_fire            = mem_req_data_valid_o & mem_req_data_ready_i;

  assign ic_resp_val_o  = resp_fire & ~owner_q[rd_ptr_q];
  assign dc_resp_val_o  = resp_fire & owner_q[rd_ptr_q];
  assign ic_resp_data_o = mem_resp_data_i;
  assign dc_resp_data_o = mem_resp_data_i;

  always_comb begin
    state_d  = state_q;
    wowner_d = wowner_q;
    wbeat_d  = wbeat_q;
    unique case (state_q)
      IDLE: begin
        if (hdr_fire && mem_req_rw_o) begin
          state_d  = WDATA;
          wowner_d = grant_dc;
          wbeat_d  = '0;
        end
      end
      WDATA: begin
        if (data_fire) begin
          if (wbeat_q == LAST_BEAT) begin
            wbeat_d = '0;
            state_d = IDLE;
          end else begin
            wbeat_d = wbeat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      wowner_q <= 1'b0;
      wbeat_q  <= '0;
    end else begin
      state_q  <= state_d;
      wowner_q <= wowner_d;
      wbeat_q  <= wbeat_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rbeat_q  <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= grant_dc;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (resp_fire) begin
        rbeat_q <= pop ? '0 : rbeat_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_resp_needs_owner: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(mem_resp_val_i && fifo_empty));
`endif

endmodule
`default_nettype wire
